// File: rtl/inv_ark_mix_if.sv
// Handshake bundle for the inverse AddRoundKey/InvMixColumns round stage.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
interface inv_ark_mix_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         skip_mix;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid, state_in, round_key, skip_mix, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, round_key, skip_mix, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/inv_ark_mix_stage.sv
// AES decryption round stage: AddRoundKey then InvMixColumns (column-serial, or bypassed for the final round).
// Define INV_MIX_PARALLEL_EN to mix all four columns in a single MIX cycle.
module inv_ark_mix_stage (
    input  logic             clk,
    input  logic             rst,
    inv_ark_mix_if.slave     bus,
    output logic [1:0]       dbg_state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MIX  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [127:0] mixed;
`ifndef INV_MIX_PARALLEL_EN
    logic [1:0]   col_cnt_q, col_cnt_d;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // s0 is the most significant byte of the column.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        return {mul_e(s0) ^ mul_b(s1) ^ mul_d(s2) ^ mul_9(s3),
                mul_9(s0) ^ mul_e(s1) ^ mul_b(s2) ^ mul_d(s3),
                mul_d(s0) ^ mul_9(s1) ^ mul_e(s2) ^ mul_b(s3),
                mul_b(s0) ^ mul_d(s1) ^ mul_9(s2) ^ mul_e(s3)};
    endfunction

    always_comb begin
        mixed = work_q;
        for (int c = 0; c < 4; c++) begin
`ifdef INV_MIX_PARALLEL_EN
            mixed[127-32*c -: 32] = inv_mix_col(work_q[127-32*c -: 32]);
`else
            if (col_cnt_q == 2'(c)) begin
                mixed[127-32*c -: 32] = inv_mix_col(work_q[127-32*c -: 32]);
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
`ifndef INV_MIX_PARALLEL_EN
        col_cnt_d = col_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.state_in ^ bus.round_key;
                    state_d = bus.skip_mix ? DONE : MIX;
`ifndef INV_MIX_PARALLEL_EN
                    col_cnt_d = 2'd0;
`endif
                end
            end
            MIX: begin
                work_d = mixed;
`ifdef INV_MIX_PARALLEL_EN
                state_d = DONE;
`else
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                // Return to IDLE only; a new block is taken on the following cycle.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
`ifndef INV_MIX_PARALLEL_EN
            col_cnt_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
`ifndef INV_MIX_PARALLEL_EN
            col_cnt_q <= col_cnt_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.state_out = work_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_inv_ark_mix_stage.sv
// Self-checking bench for inv_ark_mix_stage: directed cases plus randomized blocks against a GF(2^8) reference model.
module tb_inv_ark_mix_stage;

`ifdef INV_MIX_PARALLEL_EN
    localparam int MIX_LAT = 2;
    localparam int MIX_GAP = 3;
`else
    localparam int MIX_LAT = 5;
    localparam int MIX_GAP = 6;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_ark_mix_if bus();
    logic [1:0] dbg_state;

    inv_ark_mix_stage dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    logic rand_mode = 1'b0;
    logic rr        = 1'b1;
    logic rdy_fixed = 1'b1;
    assign bus.out_ready = rand_mode ? rr : rdy_fixed;
    always @(posedge clk) begin
        #1 rr = ($urandom_range(0, 3) != 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input logic skip);
        logic [7:0]   coef [4];
        logic [127:0] v;
        logic [127:0] o;
        logic [7:0]   acc;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        v = s ^ k;
        if (skip) return v;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], v[127-32*c-8*j -: 8]);
                end
                o[127-32*c-8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [127:0] exp_q[$];
    int           acc_hist[$];
    int           nres = 0;
    logic [127:0] last_result = '0;
    int           last_acc = 0;
    int           last_lat = 0;
    int           last_hs  = -100;
    logic         prev_ov  = 1'b0;
    logic         prev_hs  = 1'b0;
    logic [127:0] held     = '0;
    logic         follow_chk = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.state_in, bus.round_key, bus.skip_mix));
                acc_hist.push_back(cyc);
                last_acc = cyc;
                last_lat = bus.skip_mix ? 1 : MIX_LAT;
                if (follow_chk) check("accept_after_release", 128'(cyc), 128'(last_hs + 1));
            end
            if (bus.out_valid && !prev_ov) check("latency", 128'(cyc - last_acc), 128'(last_lat));
            if (bus.out_valid) check("in_ready_while_done", 128'(bus.in_ready), 128'(0));
            if (bus.out_valid && prev_ov && !prev_hs) check("hold_stable", bus.state_out, held);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 128'(1), 128'(0));
                else check("result", bus.state_out, exp_q.pop_front());
                last_result = bus.state_out;
                last_hs = cyc;
                nres++;
            end
            prev_ov = bus.out_valid;
            prev_hs = bus.out_valid && bus.out_ready;
            held    = bus.state_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_block(input logic [127:0] s, input logic [127:0] k, input logic skip);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        bus.state_in  = s;
        bus.round_key = k;
        bus.skip_mix  = skip;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 128'(1), 128'(0));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 128'(1), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 128'(1), 128'(0));
    endtask

    localparam logic [127:0] MIX_VEC = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] MIX_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] KEY_VEC = 128'h000102030405060708090a0b0c0d0e0f;

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        int nres0;
        logic [127:0] rs, rk;
        bus.in_valid  = 1'b0;
        bus.state_in  = '0;
        bus.round_key = '0;
        bus.skip_mix  = 1'b0;

        // reset release
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_state_out", bus.state_out, '0);

        // known-answer mix, zero key
        drive_block(MIX_VEC, '0, 1'b0);
        drain();
        check("kat_mix", last_result, MIX_EXP);

        // skip with key
        drive_block('0, KEY_VEC, 1'b1);
        drain();
        check("kat_skip", last_result, KEY_VEC);

        // backpressure with in_valid held high
        rdy_fixed = 1'b0;
        @(posedge clk);
        #1;
        bus.state_in  = MIX_VEC;
        bus.round_key = '0;
        bus.skip_mix  = 1'b0;
        bus.in_valid  = 1'b1;
        wait_accept();
        bus.state_in  = 128'(KEY_VEC ^ MIX_VEC);
        bus.round_key = KEY_VEC;
        bus.skip_mix  = 1'b1;
        n0 = acc_hist.size();
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        check("bp_out_valid_seen", 128'(bus.out_valid), 128'(1));
        repeat (4) @(negedge clk);
        check("bp_no_accept_while_stalled", 128'(acc_hist.size()), 128'(n0));
        @(posedge clk);
        #1;
        follow_chk = 1'b1;
        rdy_fixed  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_after_release", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        follow_chk   = 1'b0;
        check("bp_next_accepted", 128'(acc_hist.size()), 128'(n0 + 1));
        drain();
        check("bp_skip_result", last_result, MIX_VEC);

        // reset during the column-2 MIX cycle
        rdy_fixed = 1'b0;
        nres0 = nres;
        drive_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        check("abort_state_out", bus.state_out, '0);
        rdy_fixed = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_output", 128'(nres), 128'(nres0));

        // back-to-back mix blocks
        n0 = acc_hist.size();
        @(posedge clk);
        #1;
        bus.skip_mix = 1'b0;
        bus.in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.state_in  = {$urandom, $urandom, $urandom, $urandom};
            bus.round_key = {$urandom, $urandom, $urandom, $urandom};
            wait_accept();
        end
        bus.in_valid = 1'b0;
        drain();
        check("b2b_count", 128'(acc_hist.size()), 128'(n0 + 3));
        if (acc_hist.size() >= n0 + 3) begin
            check("b2b_gap1", 128'(acc_hist[n0+1] - acc_hist[n0]), 128'(MIX_GAP));
            check("b2b_gap2", 128'(acc_hist[n0+2] - acc_hist[n0+1]), 128'(MIX_GAP));
        end

        // randomized blocks with random backpressure and gaps
        rand_mode = 1'b1;
        for (int b = 0; b < 30; b++) begin
            rs = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            drive_block(rs, rk, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        rand_mode = 1'b0;
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_ark_mix_stage.md
Name: inv_ark_mix_stage

Overview:
- Decryption round stage directly downstream of the inverse S-box stage.
- Takes the 128-bit InvSubBytes result and applies AddRoundKey with the supplied round key.
- Then applies InvMixColumns column-serially, one 32-bit column per cycle, or bypasses it for the final round.
- Uses valid/ready handshakes on both sides so the round controller can stall it.

Parameters:
- None. The AES state width is fixed at 128 bits, 4 columns of 4 bytes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  state_in/round_key/skip_mix are valid
- in_ready  output  1  stage can accept a block
- state_in  input  128  InvSubBytes output; byte 0 at [127:120]; column-major order
- round_key  input  128  round key, same byte order
- skip_mix  input  1  1 = final round, bypass InvMixColumns
- out_valid  output  1  state_out holds a finished result
- out_ready  input  1  consumer accepts state_out
- state_out  output  128  round result

Behaviour:
- Byte order:
  - Column c occupies [127-32c : 96-32c].
  - Within a column, s0 is the MSB byte and s3 the LSB byte.
- FSM states: IDLE, MIX, DONE.
- Reset (synchronous):
  - state=IDLE, col_cnt=0, work register=0.
  - Outputs: in_ready=1, out_valid=0, state_out=0.
  - Reset wins over every other event, including mid-MIX and mid-DONE; partial work is discarded.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: work <= state_in ^ round_key and col_cnt <= 0.
  - Next state is DONE if skip_mix=1, otherwise MIX.
- MIX:
  - in_ready=0, out_valid=0.
  - Each cycle, column col_cnt of work is replaced by its InvMixColumns result:
    - s0' = 0e*s0 ^ 0b*s1 ^ 0d*s2 ^ 09*s3
    - s1' = 09*s0 ^ 0e*s1 ^ 0b*s2 ^ 0d*s3
    - s2' = 0d*s0 ^ 09*s1 ^ 0e*s2 ^ 0b*s3
    - s3' = 0b*s0 ^ 0d*s1 ^ 09*s2 ^ 0e*s3
  - Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1, built from xtime chains. No lookup tables.
  - col_cnt increments by 1 per cycle, 2-bit wrap.
  - After the column 3 update, next state is DONE.
  - Columns already processed are never touched again.
- DONE:
  - out_valid=1, in_ready=0, state_out=work.
  - state_out is held stable until out_ready=1.
  - On out_valid&out_ready, next state is IDLE. No same-cycle new accept.
- Latency, from accept cycle T:
  - skip_mix=1: out_valid at T+1.
  - skip_mix=0: out_valid at T+5.
- Throughput with out_ready tied high: one block per 2 cycles (skip) or per 6 cycles (mix).
- Inputs are sampled only on the accept cycle. Changes to state_in/round_key/skip_mix during MIX/DONE are ignored.
- state_out is driven from the work register, never combinationally from inputs. out_valid and in_ready are decoded from FSM state only.
- in_valid while busy is legal; it is simply not accepted.

Optional Feature:
- Macro: INV_MIX_PARALLEL_EN.
- Defined:
  - Four InvMixColumns instances update all columns in one MIX cycle; col_cnt is unused.
  - Non-skip latency is T+2; throughput is one block per 3 cycles.
  - Skip-path behaviour is unchanged.
- Undefined: column-serial operation as described above.
- Results must be bit-identical in both builds.

Test Plan:
- Reset release:
  - Stimulus: rst=1 for 2 cycles, then 0.
  - Required: in_ready=1, out_valid=0, state_out=0.
- Mix, zero key:
  - Stimulus: state_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6, round_key=0, skip_mix=0, out_ready=1.
  - Required: out_valid at T+5; state_out=db135345_f20a225c_01010101_c6c6c6c6.
- Skip with key:
  - Stimulus: state_in=0, round_key=000102030405060708090a0b0c0d0e0f, skip_mix=1.
  - Required: out_valid at T+1; state_out equals round_key.
- Backpressure:
  - Stimulus: mix vector with out_ready=0 for 4 cycles after out_valid, and in_valid held high.
  - Required: state_out stable, in_ready=0 throughout; IDLE one cycle after out_ready=1; next block accepted the following cycle.
- Reset mid-MIX:
  - Stimulus: rst=1 during the column-2 cycle.
  - Required: next cycle out_valid=0, in_ready=1, state_out=0; no output ever appears for the aborted block.
- Back-to-back:
  - Stimulus: 3 mix blocks with in_valid and out_ready held high.
  - Required: accepts at T, T+6, T+12; all three results correct. With INV_MIX_PARALLEL_EN: accepts at T, T+3, T+6.
